// File: rtl/demux5_buf.sv
// Registered 1-to-5 one-hot demultiplexer with single-entry, pass-through-ready port buffers.
// Optional feature macro DEMUX5_SEL_CHECK_EN: illegal selects are dropped and flagged on err.
module demux5_buf #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] in_data,
  input  logic [4:0]   in_sel,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] out0_data,
  output logic [N-1:0] out1_data,
  output logic [N-1:0] out2_data,
  output logic [N-1:0] out3_data,
  output logic [N-1:0] out4_data,
  output logic         out0_valid,
  output logic         out1_valid,
  output logic         out2_valid,
  output logic         out3_valid,
  output logic         out4_valid,
  input  logic         out0_ready,
  input  logic         out1_ready,
  input  logic         out2_ready,
  input  logic         out3_ready,
  input  logic         out4_ready,
  output logic         err
);

  logic [4:0]   rdy;
  logic [4:0]   valid_q;
  logic [4:0]   can_load;
  logic [4:0]   load;
  logic [N-1:0] data_q [5];

  assign rdy      = {out4_ready, out3_ready, out2_ready, out1_ready, out0_ready};
  assign can_load = ~valid_q | rdy;

`ifdef DEMUX5_SEL_CHECK_EN
  logic sel_legal;
  logic err_q;

  // Illegal selects are always accepted so a bad producer cannot stall the stream.
  assign sel_legal = $onehot(in_sel);
  assign in_ready  = sel_legal ? |(in_sel & can_load) : 1'b1;
  assign load      = (in_valid && in_ready && sel_legal) ? in_sel : 5'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_q <= 1'b0;
    else if (in_valid && !sel_legal)
      err_q <= 1'b1;
  end

  assign err = err_q;
`else
  // Broadcast waits for every selected port; a zero-hot select is accepted and dropped.
  assign in_ready = &(~in_sel | can_load);
  assign load     = (in_valid && in_ready) ? in_sel : 5'b0;
  assign err      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 5'b0;
      for (int k = 0; k < 5; k++)
        data_q[k] <= '0;
    end else begin
      for (int k = 0; k < 5; k++) begin
        if (load[k]) begin
          data_q[k]  <= in_data;
          valid_q[k] <= 1'b1;
        end else if (rdy[k]) begin
          valid_q[k] <= 1'b0;
        end
      end
    end
  end

  assign out0_data  = data_q[0];
  assign out1_data  = data_q[1];
  assign out2_data  = data_q[2];
  assign out3_data  = data_q[3];
  assign out4_data  = data_q[4];
  assign out0_valid = valid_q[0];
  assign out1_valid = valid_q[1];
  assign out2_valid = valid_q[2];
  assign out3_valid = valid_q[3];
  assign out4_valid = valid_q[4];

endmodule

// File: tb/tb_demux5_buf.sv
// Directed bench for demux5_buf with a per-port scoreboard of expected payloads.
module tb_demux5_buf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic [4:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] od [5];
  logic [4:0]  ov;
  logic [4:0]  ordy;
  logic        err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          port;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  demux5_buf #(.N(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .out0_data(od[0]), .out1_data(od[1]), .out2_data(od[2]), .out3_data(od[3]), .out4_data(od[4]),
    .out0_valid(ov[0]), .out1_valid(ov[1]), .out2_valid(ov[2]), .out3_valid(ov[3]), .out4_valid(ov[4]),
    .out0_ready(ordy[0]), .out1_ready(ordy[1]), .out2_ready(ordy[2]), .out3_ready(ordy[3]),
    .out4_ready(ordy[4]),
    .err(err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive at the falling edge, resolve handshakes in the scoreboard, advance.
  task automatic step(input logic [4:0] sel, input logic [31:0] data, input logic valid);
    int found;
    in_sel   = sel;
    in_data  = data;
    in_valid = valid;
    #1;
    for (int k = 0; k < 5; k++) begin
      if (ov[k] && ordy[k]) begin
        found = -1;
        for (int i = 0; i < sb.size(); i++)
          if (sb[i].port == k && found < 0) found = i;
        check($sformatf("sb_pending_p%0d", k), {31'b0, found >= 0}, 32'd1);
        if (found >= 0) begin
          check($sformatf("sb_data_p%0d", k), od[k], sb[found].data);
          sb.delete(found);
        end
      end
    end
    if (valid && in_ready) begin
`ifdef DEMUX5_SEL_CHECK_EN
      if ($onehot(sel))
`endif
        for (int k = 0; k < 5; k++)
          if (sel[k]) sb.push_back('{port: k, data: data});
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic probe_ready(input string tag, input logic [4:0] sel, input logic exp);
    in_sel = sel;
    #1;
    check(tag, {31'b0, in_ready}, {31'b0, exp});
  endtask

  initial begin
    rst_n    = 1'b0;
    in_data  = '0;
    in_sel   = '0;
    in_valid = 1'b0;
    ordy     = '0;
    repeat (2) @(negedge clk);
    check("rst_valid", {27'b0, ov}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single steer into a blocked port 2.
    probe_ready("ready_p2_empty", 5'b00100, 1'b1);
    step(5'b00100, 32'hDEADBEEF, 1'b1);
    for (int c = 0; c < 10; c++) begin
      check("hold_p2_valid", {31'b0, ov[2]}, 32'd1);
      check("hold_p2_data", od[2], 32'hDEADBEEF);
      step(5'b00000, 32'h0, 1'b0);
    end
    in_valid = 1'b1;
    probe_ready("ready_p2_full", 5'b00100, 1'b0);
    step(5'b00100, 32'h22222222, 1'b1);
    check("p2_not_replaced", od[2], 32'hDEADBEEF);
    probe_ready("ready_p0", 5'b00001, 1'b1);
    step(5'b00001, 32'h11111111, 1'b1);
    check("p0_valid", {31'b0, ov[0]}, 32'd1);
    check("p0_data", od[0], 32'h11111111);
    ordy = 5'b00101;
    step(5'b00000, 32'h0, 1'b0);
    check("drain_valid", {27'b0, ov}, 32'd0);

    // Pass-through stream into port 4 with its consumer always ready.
    ordy = 5'b10000;
    step(5'b10000, 32'd0, 1'b1);
    for (int i = 1; i < 8; i++) begin
      probe_ready("ready_p4_pass", 5'b10000, 1'b1);
      step(5'b10000, i, 1'b1);
      check("p4_valid_stream", {31'b0, ov[4]}, 32'd1);
      check("p4_data_stream", od[4], i);
    end
    step(5'b00000, 32'h0, 1'b0);
    check("p4_empty", {31'b0, ov[4]}, 32'd0);

    // Load port 0 while ports 1 and 2 drain.
    ordy = 5'b00000;
    step(5'b00010, 32'hAAAA0001, 1'b1);
    step(5'b00100, 32'hAAAA0002, 1'b1);
    ordy = 5'b00110;
    step(5'b00001, 32'hAAAA0000, 1'b1);
    check("sim_p0", {31'b0, ov[0]}, 32'd1);
    check("sim_p1", {31'b0, ov[1]}, 32'd0);
    check("sim_p2", {31'b0, ov[2]}, 32'd0);
    ordy = 5'b00001;
    step(5'b00000, 32'h0, 1'b0);

    // Asynchronous reset with ports 1 and 3 full.
    ordy = 5'b00000;
    step(5'b00010, 32'hBBBB0001, 1'b1);
    step(5'b01000, 32'hBBBB0003, 1'b1);
    check("pre_rst_full", {27'b0, ov}, 32'h0A);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", {27'b0, ov}, 32'd0);
    check("arst_data1", od[1], 32'd0);
    check("arst_err", {31'b0, err}, 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    probe_ready("ready_after_rst", 5'b00100, 1'b1);

`ifdef DEMUX5_SEL_CHECK_EN
    probe_ready("ready_multihot", 5'b00110, 1'b1);
    step(5'b00110, 32'hCCCC0001, 1'b1);
    check("illegal_noload", {27'b0, ov}, 32'd0);
    check("err_set", {31'b0, err}, 32'd1);
    step(5'b00000, 32'h0, 1'b0);
    check("err_sticky", {31'b0, err}, 32'd1);
    probe_ready("ready_zerohot", 5'b00000, 1'b1);
    step(5'b00000, 32'hCCCC0002, 1'b1);
    check("zerohot_noload", {27'b0, ov}, 32'd0);
    check("err_sticky2", {31'b0, err}, 32'd1);
`else
    ordy = 5'b00000;
    step(5'b10000, 32'hDDDD0004, 1'b1);
    in_valid = 1'b1;
    probe_ready("ready_bcast_blocked", 5'b10001, 1'b0);
    step(5'b10001, 32'hDDDD9999, 1'b1);
    check("bcast_blocked_p0", {31'b0, ov[0]}, 32'd0);
    ordy = 5'b10000;
    probe_ready("ready_bcast_open", 5'b10001, 1'b1);
    step(5'b10001, 32'hDDDD0041, 1'b1);
    check("bcast_valid", {27'b0, ov}, 32'h11);
    check("bcast_p0", od[0], 32'hDDDD0041);
    check("bcast_p4", od[4], 32'hDDDD0041);
    check("bcast_err", {31'b0, err}, 32'd0);
    ordy = 5'b11111;
    step(5'b00000, 32'h0, 1'b0);
    probe_ready("ready_zerohot", 5'b00000, 1'b1);
    step(5'b00000, 32'hEEEE0000, 1'b1);
    check("zerohot_noload", {27'b0, ov}, 32'd0);
`endif

    check("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/demux5_buf.md
# demux5_buf

Registered 5-way one-hot demultiplexer: the transmit-side counterpart of the one-hot 5-input mux used in the memory datapath. One valid/ready input stream is steered by a one-hot destination select into one of five output ports. Each port has a single-entry output register. The block sits between a memory response source and five consumers that would otherwise share a one-hot mux on the return path.

## Interface
- `N`, 32, data width in bits.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_data`  in  N  input payload.
- `in_sel`  in  5  destination select; bit k selects port k; expected one-hot.
- `in_valid`  in  1  input transfer request.
- `in_ready`  out  1  input can be accepted this cycle (combinational).
- `out0_data` … `out4_data`  out  N each  port payload (registered).
- `out0_valid` … `out4_valid`  out  1 each  port holds a valid entry (registered).
- `out0_ready` … `out4_ready`  in  1 each  consumer accepts the port entry.
- `err`  out  1  sticky select-error flag (registered).

## Operation
- Each port k has a 1-entry buffer made of `outk_data` and `outk_valid`.
- Port k can load when `!outk_valid || outk_ready`. This is pass-through ready: a full port drained in the same cycle accepts a new entry.
- **Input accept:** a transfer occurs when `in_valid && in_ready`.
- **`in_ready` with exactly one `in_sel` bit set:** `in_ready` equals "can load" of the selected port.
  - On a transfer, port k loads `in_data` and sets `outk_valid=1` on the next edge.
- **Output handshake:** port k clears `outk_valid` on an edge where `outk_valid && outk_ready` and it does not load.
  - If it loads in that same cycle, `outk_valid` stays 1 and the data is replaced.
- **Data stability:** `outk_data` must hold stable while `outk_valid && !outk_ready`.
  - A blocked port never back-pressures the other ports.
- **Simultaneous events:** an input load to one port and drains on any set of ports all occur in the same cycle, independently.
- **No state machine:** behaviour is a per-port valid bit plus the input steering logic.
- **Zero-hot and multi-hot `in_sel`:** behaviour is set by Configuration.

## Timing
- Latency: an input accepted on edge t is visible at `outk_valid`/`outk_data` after edge t.
- Throughput: 1 transfer/cycle to a given port when its consumer holds ready=1. Back-to-back transfers to different ports are also 1/cycle.
- `in_ready` is a combinational function of `in_sel`, `outk_valid` and `outk_ready`.
  - There is no path from `in_valid` to `in_ready`.
- **Reset (`rst_n`=0, asynchronous):**
  - all `outk_valid`=0, all `outk_data`=0, `err`=0.
  - `in_ready` then evaluates with all buffers empty, so it is 1 for a one-hot select.
- **Reset mid-operation:** buffered entries are discarded with no drain.
- **Release of `rst_n`:** synchronous to `clk` by the system.

## Configuration
- Feature macro: `DEMUX5_SEL_CHECK_EN`.
- **Defined:** a zero-hot or multi-hot `in_sel` is illegal.
  - `in_ready`=1 for it.
  - A transfer with an illegal select is consumed and dropped; no port loads.
  - `err` sets on the next edge and stays 1 until reset.
- **Not defined:** multi-hot `in_sel` broadcasts.
  - `in_ready` = AND of "can load" over all selected ports.
  - On a transfer, every selected port loads the same `in_data`.
  - Zero-hot `in_sel`: `in_ready`=1 and the transfer is silently dropped.
  - `err` is tied to 0.

## Test plan
- **Reset:** assert `rst_n`=0 mid-traffic with ports 1 and 3 full.
  - Required: all `outk_valid`=0, `err`=0 immediately (asynchronously).
  - Required: `in_ready`=1 for `in_sel`=5'b00100 after release.
- **Single steer:** `in_sel`=5'b00100, `in_data`=32'hDEADBEEF, valid 1 cycle, `out2_ready`=0.
  - Required: `out2_valid`=1 and `out2_data`=32'hDEADBEEF next cycle, held for 10 cycles.
  - Required: a second write to port 2 sees `in_ready`=0.
  - Required: a write to port 0 is accepted.
- **Pass-through:** port 4 full with `out4_ready`=1 and a new input to port 4 in the same cycle.
  - Required: `in_ready`=1 and `out4_valid` stays 1 with the new data.
  - Required: 8 consecutive words 0..7 arrive in order, one per cycle.
- **Simultaneous:** load port 0 while ports 1 and 2 drain in the same cycle.
  - Required: `out0_valid`=1, `out1_valid`=0, `out2_valid`=0 after the edge.
- **Check enabled:** `in_sel`=5'b00110, valid 1 cycle.
  - Required: `in_ready`=1, no port loads, `err`=1 after the edge and sticky.
  - Required: repeat with `in_sel`=5'b00000 gives the same result.
- **Check disabled:** `in_sel`=5'b10001 with port 4 full and `out4_ready`=0.
  - Required: `in_ready`=0.
  - Then raise `out4_ready`=1. Required: ports 0 and 4 both load the same data; `err` stays 0.
